// File: rtl/load_store_unit_axi_lite_ready_if.sv
// Data-memory request/response bus between the load/store unit (master) and memory (slave).
interface load_store_unit_axi_lite_ready_if #(
  parameter int XLEN = 32
);
  localparam int LANES = XLEN / 8;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_write;
  logic [XLEN-1:0]  mem_address;
  logic [LANES-1:0] mem_strobe;
  logic [XLEN-1:0]  mem_write_data;
  logic             mem_resp_valid;
  logic [XLEN-1:0]  mem_read_data;

  modport master (
    output mem_req_valid, mem_write, mem_address, mem_strobe, mem_write_data,
    input  mem_req_ready, mem_resp_valid, mem_read_data
  );

  modport slave (
    input  mem_req_valid, mem_write, mem_address, mem_strobe, mem_write_data,
    output mem_req_ready, mem_resp_valid, mem_read_data
  );
endinterface

// File: rtl/load_store_unit_axi_lite_ready.sv
// RISC-V load/store unit with valid/ready data-memory handshake and response timeout.
// Optional LSU_MISALIGN_SPLIT_EN: word-crossing accesses become two beats instead of a trap.
module load_store_unit_axi_lite_ready #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            enable,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            done,
  output logic            busy,
  output logic            misaligned,
  output logic            bus_error,
  load_store_unit_axi_lite_ready_if.master mem
);
  localparam int LANES = XLEN / 8;
  localparam int OW    = $clog2(LANES);
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
`ifdef LSU_MISALIGN_SPLIT_EN
    S_REQ2,
    S_RESP2,
`endif
    S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic            r_store, r_uns, r_mis, r_berr;
  logic [1:0]      r_size;
  logic [XLEN-1:0] r_addr, r_wdata, r_load_data;
  logic [CW-1:0]   r_cnt;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic            r_split;
  logic [XLEN-1:0] r_rd1;
  logic            w_in_split;
`endif

  logic            w_is_load, w_is_store, w_illegal, w_in_mis, w_trap, w_to;
  logic            w_berr_set, w_load_upd, w_sbit;
  logic [OW-1:0]   w_in_off, w_in_szm1, w_off;
  logic [2*LANES-1:0] w_bmask;
  logic [2*XLEN-1:0]  w_wdext, w_rdcat;
  logic [XLEN-1:0] w_base, w_shift, w_mask, w_ext;

  assign w_is_load  = (opcode == 7'b0000011);
  assign w_is_store = (opcode == 7'b0100011);
  assign w_illegal  = !(w_is_load || w_is_store) || (XLEN == 32 && funct3[1:0] == 2'b11)
                   || (funct3 == 3'b111) || (w_is_store && funct3[2]);
  assign w_in_off   = address[OW-1:0];
  assign w_in_szm1  = OW'((4'd1 << funct3[1:0]) - 4'd1);
  assign w_in_mis   = |(w_in_off & w_in_szm1);
`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_in_split = ({1'b0, w_in_off} + (OW+1)'(4'd1 << funct3[1:0])) > (OW+1)'(LANES);
  assign w_trap     = 1'b0;
`else
  assign w_trap     = w_in_mis;
`endif

  // Lane masks and data are built double-width so the upper half feeds a second beat.
  assign w_off   = r_addr[OW-1:0];
  assign w_base  = {r_addr[XLEN-1:OW], {OW{1'b0}}};
  assign w_bmask = (2*LANES)'((9'd1 << (4'd1 << r_size)) - 9'd1);
  assign w_wdext = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_to    = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_rdcat = {{XLEN{1'b0}}, mem.mem_read_data};
`ifdef LSU_MISALIGN_SPLIT_EN
    if (r_state == S_RESP2) w_rdcat = {mem.mem_read_data, r_rd1};
`endif
    w_shift = XLEN'(w_rdcat >> {w_off, 3'b000});
    w_mask  = '1;
    w_sbit  = w_shift[XLEN-1];
    case (r_size)
      2'd0: begin w_mask = XLEN'(8'hFF);         w_sbit = w_shift[7];  end
      2'd1: begin w_mask = XLEN'(16'hFFFF);      w_sbit = w_shift[15]; end
      2'd2: begin w_mask = XLEN'(32'hFFFF_FFFF); w_sbit = w_shift[31]; end
      default: ;
    endcase
    w_ext = (w_shift & w_mask) | ((!r_uns && w_sbit) ? ~w_mask : '0);
  end

  always_comb begin
    w_next              = r_state;
    w_berr_set          = 1'b0;
    w_load_upd          = 1'b0;
    mem.mem_req_valid   = 1'b0;
    mem.mem_write       = 1'b0;
    mem.mem_address     = '0;
    mem.mem_strobe      = '0;
    mem.mem_write_data  = '0;
    case (r_state)
      S_IDLE: if (enable) w_next = (w_illegal || w_trap) ? S_DONE : S_REQ;
      S_REQ: begin
        mem.mem_req_valid  = 1'b1;
        mem.mem_write      = r_store;
        mem.mem_address    = w_base;
        mem.mem_strobe     = LANES'(w_bmask << w_off);
        mem.mem_write_data = XLEN'(w_wdext);
        if (mem.mem_req_ready) w_next = S_RESP;
        else if (w_to) begin w_next = S_DONE; w_berr_set = 1'b1; end
      end
      S_RESP: begin
        if (mem.mem_resp_valid) begin
          w_next     = S_DONE;
          w_load_upd = !r_store;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (r_split) begin w_next = S_REQ2; w_load_upd = 1'b0; end
`endif
        end else if (w_to) begin w_next = S_DONE; w_berr_set = 1'b1; end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_REQ2: begin
        mem.mem_req_valid  = 1'b1;
        mem.mem_write      = r_store;
        mem.mem_address    = w_base + XLEN'(LANES);
        mem.mem_strobe     = LANES'((w_bmask << w_off) >> LANES);
        mem.mem_write_data = XLEN'(w_wdext >> XLEN);
        if (mem.mem_req_ready) w_next = S_RESP2;
        else if (w_to) begin w_next = S_DONE; w_berr_set = 1'b1; end
      end
      S_RESP2: begin
        if (mem.mem_resp_valid) begin w_next = S_DONE; w_load_upd = !r_store; end
        else if (w_to) begin w_next = S_DONE; w_berr_set = 1'b1; end
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_store     <= 1'b0;
      r_uns       <= 1'b0;
      r_mis       <= 1'b0;
      r_berr      <= 1'b0;
      r_size      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
      r_cnt       <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split     <= 1'b0;
      r_rd1       <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state != S_IDLE && r_state != S_DONE) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_IDLE && enable) begin
        r_store <= w_is_store;
        r_uns   <= funct3[2];
        r_size  <= funct3[1:0];
        r_addr  <= address;
        r_wdata <= store_data;
        r_mis   <= !w_illegal && w_trap;
        r_berr  <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        r_split <= !w_illegal && w_in_split;
`endif
      end
      if (w_berr_set) r_berr <= 1'b1;
      if (w_load_upd) r_load_data <= w_ext;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (r_state == S_RESP && mem.mem_resp_valid) r_rd1 <= mem.mem_read_data;
`endif
    end
  end

  assign load_data  = r_load_data;
  assign done       = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign misaligned = done && r_mis;
  assign bus_error  = done && r_berr;
endmodule

// File: tb/tb_load_store_unit_axi_lite_ready.sv
// Directed bench: XLEN=32/TIMEOUT=4 instance plus an XLEN=64 instance for wide-lane cases.
module tb_load_store_unit_axi_lite_ready;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        en_a, en_b;
  logic [31:0] addr_a, sd_a, ld_a;
  logic [63:0] addr_b, sd_b, ld_b;
  logic        done_a, busy_a, mis_a, berr_a;
  logic        done_b, busy_b, mis_b, berr_b;
  logic [31:0] last_ld;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  load_store_unit_axi_lite_ready_if #(.XLEN(32)) bus_a ();
  load_store_unit_axi_lite_ready_if #(.XLEN(64)) bus_b ();

  load_store_unit_axi_lite_ready #(.XLEN(32), .TIMEOUT(4)) dut_a (
    .CLK(clk), .reset(rst), .enable(en_a), .opcode(op), .funct3(f3),
    .address(addr_a), .store_data(sd_a), .load_data(ld_a), .done(done_a),
    .busy(busy_a), .misaligned(mis_a), .bus_error(berr_a), .mem(bus_a.master)
  );

  load_store_unit_axi_lite_ready #(.XLEN(64), .TIMEOUT(255)) dut_b (
    .CLK(clk), .reset(rst), .enable(en_b), .opcode(op), .funct3(f3),
    .address(addr_b), .store_data(sd_b), .load_data(ld_b), .done(done_b),
    .busy(busy_b), .misaligned(mis_b), .bus_error(berr_b), .mem(bus_b.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({ld_a, done_a, busy_a, mis_a, berr_a} !== 36'h0) begin
      n_err++; $display("FAIL reset_outs_a got %h/%b%b%b%b want 0", ld_a, done_a, busy_a, mis_a, berr_a);
    end
    n_cmp++;
    if ({bus_a.mem_req_valid, bus_a.mem_write, bus_a.mem_strobe, bus_a.mem_address, bus_a.mem_write_data} !== 70'h0) begin
      n_err++; $display("FAIL reset_mem_a got v=%b a=%h s=%b d=%h want 0", bus_a.mem_req_valid, bus_a.mem_address, bus_a.mem_strobe, bus_a.mem_write_data);
    end
    n_cmp++;
    if ({ld_b, done_b, busy_b, bus_b.mem_req_valid} !== 67'h0) begin
      n_err++; $display("FAIL reset_outs_b got ld=%h d=%b b=%b v=%b want 0", ld_b, done_b, busy_b, bus_b.mem_req_valid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_byte();
    op = OP_LD; f3 = 3'b000; addr_a = 32'h1003; en_a = 1'b1;
    tick();
    en_a = 1'b0;
    n_cmp++;
    if ({bus_a.mem_req_valid, bus_a.mem_write, bus_a.mem_strobe, bus_a.mem_address} !== {1'b1, 1'b0, 4'b1000, 32'h1000}) begin
      n_err++; $display("FAIL lb_req got v=%b w=%b s=%b a=%h want 1 0 1000 00001000", bus_a.mem_req_valid, bus_a.mem_write, bus_a.mem_strobe, bus_a.mem_address);
    end
    bus_a.mem_req_ready = 1'b1;
    tick();
    bus_a.mem_req_ready = 1'b0;
    n_cmp++;
    if ({bus_a.mem_req_valid, done_a, busy_a} !== 3'b001) begin
      n_err++; $display("FAIL lb_resp_wait got v=%b d=%b b=%b want 0 0 1", bus_a.mem_req_valid, done_a, busy_a);
    end
    bus_a.mem_resp_valid = 1'b1; bus_a.mem_read_data = 32'h80AABBCC;
    tick();
    bus_a.mem_resp_valid = 1'b0;
    n_cmp++;
    if ({done_a, mis_a, berr_a} !== 3'b100) begin
      n_err++; $display("FAIL lb_done_c3 got %b%b%b want 100", done_a, mis_a, berr_a);
    end
    n_cmp++;
    if (ld_a !== 32'hFFFFFF80) begin
      n_err++; $display("FAIL lb_data got %h want ffffff80", ld_a);
    end
    last_ld = 32'hFFFFFF80;
    tick();
    n_cmp++;
    if ({done_a, busy_a} !== 2'b00) begin
      n_err++; $display("FAIL lb_idle got d=%b b=%b want 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_store_half();
    op = OP_ST; f3 = 3'b001; addr_a = 32'h2002; sd_a = 32'h1234ABCD; en_a = 1'b1;
    tick();
    op = OP_LD; addr_a = 32'h3000;  // enable still high while busy: must be ignored
    n_cmp++;
    if ({bus_a.mem_req_valid, bus_a.mem_write, bus_a.mem_strobe, bus_a.mem_address, bus_a.mem_write_data}
        !== {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hABCD0000}) begin
      n_err++; $display("FAIL sh_req got v=%b w=%b s=%b a=%h d=%h want 1 1 1100 00002000 abcd0000",
                        bus_a.mem_req_valid, bus_a.mem_write, bus_a.mem_strobe, bus_a.mem_address, bus_a.mem_write_data);
    end
    bus_a.mem_req_ready = 1'b1;
    tick();
    en_a = 1'b0; bus_a.mem_req_ready = 1'b0;
    bus_a.mem_resp_valid = 1'b1; bus_a.mem_read_data = 32'hDEADBEEF;
    tick();
    bus_a.mem_resp_valid = 1'b0;
    n_cmp++;
    if ({done_a, mis_a, berr_a} !== 3'b100 || ld_a !== last_ld) begin
      n_err++; $display("FAIL sh_done got d=%b m=%b e=%b ld=%h want 1 0 0 ld=%h", done_a, mis_a, berr_a, ld_a, last_ld);
    end
    tick();
    n_cmp++;
    if ({done_a, busy_a, bus_a.mem_req_valid} !== 3'b000) begin
      n_err++; $display("FAIL sh_idle got d=%b b=%b v=%b want 000", done_a, busy_a, bus_a.mem_req_valid);
    end
  endtask

  task automatic test_load_variants();
    logic [2:0]  vf [4] = '{3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] va [4] = '{32'h1001, 32'h1000, 32'h1002, 32'h1004};
    logic [31:0] vd [4] = '{32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC, 32'h7F00FF01};
    logic [31:0] ve [4] = '{32'h000000BB, 32'hFFFFBBCC, 32'h000080AA, 32'h7F00FF01};
    for (int i = 0; i < 4; i++) begin
      op = OP_LD; f3 = vf[i]; addr_a = va[i]; en_a = 1'b1;
      tick();
      en_a = 1'b0; bus_a.mem_req_ready = 1'b1;
      tick();
      bus_a.mem_req_ready = 1'b0; bus_a.mem_resp_valid = 1'b1; bus_a.mem_read_data = vd[i];
      tick();
      bus_a.mem_resp_valid = 1'b0;
      n_cmp++;
      if (done_a !== 1'b1 || ld_a !== ve[i]) begin
        n_err++; $display("FAIL load_var%0d got d=%b ld=%h want 1 %h", i, done_a, ld_a, ve[i]);
      end
      last_ld = ve[i];
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [6:0] vo [3] = '{7'b0110011, OP_ST, OP_LD};
    logic [2:0] vf [3] = '{3'b010, 3'b100, 3'b011};
    for (int i = 0; i < 3; i++) begin
      op = vo[i]; f3 = vf[i]; addr_a = 32'h1000; en_a = 1'b1;
      tick();
      en_a = 1'b0;
      n_cmp++;
      if ({done_a, mis_a, berr_a, bus_a.mem_req_valid} !== 4'b1000 || ld_a !== last_ld) begin
        n_err++; $display("FAIL illegal%0d got d=%b m=%b e=%b v=%b ld=%h want 1000 ld=%h",
                          i, done_a, mis_a, berr_a, bus_a.mem_req_valid, ld_a, last_ld);
      end
      tick();
    end
  endtask

  task automatic test_misaligned();
    op = OP_LD; f3 = 3'b010; addr_a = 32'h0101; en_a = 1'b1;
    tick();
    en_a = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    n_cmp++;
    if ({bus_a.mem_req_valid, bus_a.mem_strobe, bus_a.mem_address} !== {1'b1, 4'b1110, 32'h0100}) begin
      n_err++; $display("FAIL split_b1 got v=%b s=%b a=%h want 1 1110 00000100", bus_a.mem_req_valid, bus_a.mem_strobe, bus_a.mem_address);
    end
    bus_a.mem_req_ready = 1'b1;
    tick();
    bus_a.mem_req_ready = 1'b0; bus_a.mem_resp_valid = 1'b1; bus_a.mem_read_data = 32'h44332211;
    tick();
    bus_a.mem_resp_valid = 1'b0;
    n_cmp++;
    if ({bus_a.mem_req_valid, bus_a.mem_strobe, bus_a.mem_address} !== {1'b1, 4'b0001, 32'h0104}) begin
      n_err++; $display("FAIL split_b2 got v=%b s=%b a=%h want 1 0001 00000104", bus_a.mem_req_valid, bus_a.mem_strobe, bus_a.mem_address);
    end
    bus_a.mem_req_ready = 1'b1;
    tick();
    bus_a.mem_req_ready = 1'b0; bus_a.mem_resp_valid = 1'b1; bus_a.mem_read_data = 32'hAAAAAA55;
    tick();
    bus_a.mem_resp_valid = 1'b0;
    n_cmp++;
    if ({done_a, mis_a, berr_a} !== 3'b100 || ld_a !== 32'h55443322) begin
      n_err++; $display("FAIL split_done got d=%b m=%b e=%b ld=%h want 100 55443322", done_a, mis_a, berr_a, ld_a);
    end
    last_ld = 32'h55443322;
`else
    n_cmp++;
    if ({done_a, mis_a, berr_a, bus_a.mem_req_valid} !== 4'b1100 || ld_a !== last_ld) begin
      n_err++; $display("FAIL misalign got d=%b m=%b e=%b v=%b ld=%h want 1100 ld=%h",
                        done_a, mis_a, berr_a, bus_a.mem_req_valid, ld_a, last_ld);
    end
`endif
    tick();
    n_cmp++;
    if ({done_a, mis_a, busy_a} !== 3'b000) begin
      n_err++; $display("FAIL misalign_after got d=%b m=%b b=%b want 000", done_a, mis_a, busy_a);
    end
  endtask

  task automatic test_timeout();
    op = OP_LD; f3 = 3'b010; addr_a = 32'h1000; en_a = 1'b1;
    tick();
    en_a = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if ({bus_a.mem_req_valid, done_a} !== 2'b10) begin
        n_err++; $display("FAIL timeout_hold_c%0d got v=%b d=%b want 1 0", c, bus_a.mem_req_valid, done_a);
      end
      tick();
    end
    n_cmp++;
    if ({bus_a.mem_req_valid, done_a, mis_a, berr_a} !== 4'b0101 || ld_a !== last_ld) begin
      n_err++; $display("FAIL timeout_end got v=%b d=%b m=%b e=%b ld=%h want 0101 ld=%h",
                        bus_a.mem_req_valid, done_a, mis_a, berr_a, ld_a, last_ld);
    end
    tick();
    n_cmp++;
    if ({done_a, berr_a, busy_a} !== 3'b000) begin
      n_err++; $display("FAIL timeout_after got d=%b e=%b b=%b want 000", done_a, berr_a, busy_a);
    end
  endtask

  task automatic test_reset_in_resp();
    op = OP_LD; f3 = 3'b010; addr_a = 32'h1000; en_a = 1'b1;
    tick();
    en_a = 1'b0; bus_a.mem_req_ready = 1'b1;
    tick();
    bus_a.mem_req_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({ld_a, done_a, busy_a, bus_a.mem_req_valid, bus_a.mem_strobe, bus_a.mem_address} !== 71'h0) begin
      n_err++; $display("FAIL rst_resp got ld=%h d=%b b=%b v=%b s=%b a=%h want 0",
                        ld_a, done_a, busy_a, bus_a.mem_req_valid, bus_a.mem_strobe, bus_a.mem_address);
    end
    bus_a.mem_resp_valid = 1'b1; bus_a.mem_read_data = 32'h11111111;
    tick();
    bus_a.mem_resp_valid = 1'b0;
    n_cmp++;
    if ({done_a, busy_a, ld_a} !== 34'h0) begin
      n_err++; $display("FAIL late_resp got d=%b b=%b ld=%h want 0 0 0", done_a, busy_a, ld_a);
    end
    tick();
    n_cmp++;
    if (done_a !== 1'b0) begin
      n_err++; $display("FAIL late_resp2 got d=%b want 0", done_a);
    end
    last_ld = 32'h0;
  endtask

  task automatic test_wide();
    op = OP_LD; f3 = 3'b110; addr_b = 64'h8; en_b = 1'b1;
    tick();
    en_b = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      n_cmp++;
      if ({bus_b.mem_req_valid, bus_b.mem_strobe, bus_b.mem_address, done_b} !== {1'b1, 8'h0F, 64'h8, 1'b0}) begin
        n_err++; $display("FAIL lwu_stall_c%0d got v=%b s=%b a=%h d=%b want 1 00001111 8 0",
                          c, bus_b.mem_req_valid, bus_b.mem_strobe, bus_b.mem_address, done_b);
      end
      tick();
    end
    bus_b.mem_req_ready = 1'b1;
    tick();
    bus_b.mem_req_ready = 1'b0; bus_b.mem_resp_valid = 1'b1; bus_b.mem_read_data = 64'hF000_0000_0000_0000;
    n_cmp++;
    if (done_b !== 1'b0) begin
      n_err++; $display("FAIL lwu_early got d=%b want 0", done_b);
    end
    tick();
    bus_b.mem_resp_valid = 1'b0;
    n_cmp++;
    if (done_b !== 1'b1 || ld_b !== 64'h0) begin
      n_err++; $display("FAIL lwu_done_c5 got d=%b ld=%h want 1 0", done_b, ld_b);
    end
    tick();
    f3 = 3'b010; addr_b = 64'hC; en_b = 1'b1;
    tick();
    en_b = 1'b0;
    n_cmp++;
    if ({bus_b.mem_strobe, bus_b.mem_address} !== {8'hF0, 64'h8}) begin
      n_err++; $display("FAIL lw64_req got s=%b a=%h want 11110000 8", bus_b.mem_strobe, bus_b.mem_address);
    end
    bus_b.mem_req_ready = 1'b1;
    tick();
    bus_b.mem_req_ready = 1'b0; bus_b.mem_resp_valid = 1'b1; bus_b.mem_read_data = 64'h8000_0001_1234_5678;
    tick();
    bus_b.mem_resp_valid = 1'b0;
    n_cmp++;
    if (done_b !== 1'b1 || ld_b !== 64'hFFFF_FFFF_8000_0001) begin
      n_err++; $display("FAIL lw64_data got d=%b ld=%h want 1 ffffffff80000001", done_b, ld_b);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; op = '0; f3 = '0; en_a = 1'b0; en_b = 1'b0;
    addr_a = '0; sd_a = '0; addr_b = '0; sd_b = '0; last_ld = '0;
    bus_a.mem_req_ready = 1'b0; bus_a.mem_resp_valid = 1'b0; bus_a.mem_read_data = '0;
    bus_b.mem_req_ready = 1'b0; bus_b.mem_resp_valid = 1'b0; bus_b.mem_read_data = '0;
    #2;
    test_reset();
    test_load_byte();
    test_store_half();
    test_load_variants();
    test_illegal();
    test_misaligned();
    test_timeout();
    test_reset_in_resp();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
